// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef logic [0:0] state_t;

    localparam state_t     c_ST_RUN     = 1'b0;
    localparam state_t     c_ST_BUSY    = 1'b1;

    localparam logic [4:0] c_REG_ZERO   = 5'd0;

    localparam int         c_MC_LAT_MIN = 2;
    localparam int         c_MC_LAT_MAX = 15;
    localparam int         c_CNT_W      = 4;

    function automatic bit mc_lat_ok(input int lat);
        return (lat >= c_MC_LAT_MIN) && (lat <= c_MC_LAT_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_mc_timer.sv
`default_nettype none
// ============================================================================
// Module      : hazard_mc_timer
// Description : RUN/BUSY sequencer that freezes the front end while a
//               multi-cycle EX operation completes.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_mc_timer
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy_lock,
    output logic busy
);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MC_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    if (!mc_lat_ok(MC_LAT)) begin : g_lat_check
        $error("hazard_mc_timer: MC_LAT must lie in 2..15");
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The start cycle itself is locked by the caller, so BUSY covers MC_LAT-1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_RUN: begin
                if (start) begin
                    w_state_nxt = c_ST_BUSY;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            c_ST_BUSY: begin
                if (r_cnt > c_CNT_ONE) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy      = (r_state == c_ST_BUSY);
        busy_lock = (r_state == c_ST_BUSY) && (r_cnt > c_CNT_ONE);
    end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard controller producing stage lock/flush
//               controls plus saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 4,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              ex_branch_taken,
    input  logic              ex_mc_start,
    input  logic              perf_clr,
    output logic              pc_lock,
    output logic              ifid_lock,
    output logic              ifid_flush,
    output logic              idex_lock,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam logic [PERF_W-1:0] c_PERF_MAX = '1;

    logic              w_busy;
    logic              w_busy_lock;
    logic              w_run;
    logic              w_branch;
    logic              w_mc_start;
    logic              w_rt_match;
    logic              w_load_use;
    logic              w_jump;
    logic              w_mc_lock;
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    hazard_mc_timer #(
        .MC_LAT    (MC_LAT)
    ) u_mc_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (w_mc_start),
        .busy_lock (w_busy_lock),
        .busy      (w_busy)
    );

    // Priority decode: branch > multi-cycle start > load-use > jump, RUN only.
    always_comb begin
        w_run      = rst && !w_busy;
        w_branch   = w_run && ex_branch_taken;
        w_mc_start = w_run && !ex_branch_taken && ex_mc_start;
        w_rt_match = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
        w_load_use = w_run && !ex_branch_taken && !ex_mc_start && ex_mem_read
                     && (ex_rt != c_REG_ZERO) && w_rt_match;
        w_jump     = w_run && !ex_branch_taken && !ex_mc_start && !w_load_use && id_jump;
        w_mc_lock  = w_mc_start || (rst && w_busy_lock);
    end

    assign pc_lock     = w_mc_lock || w_load_use;
    assign ifid_lock   = w_mc_lock || w_load_use;
    assign ifid_flush  = w_branch || w_jump;
    assign idex_lock   = w_mc_lock;
    assign idex_flush  = w_branch || w_load_use;
    assign exmem_flush = w_mc_lock;
    assign mc_busy     = w_busy;

    always_ff @(posedge clk) begin
        if (!rst || perf_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_lock && (r_stall_cnt != c_PERF_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (ifid_flush && (r_flush_cnt != c_PERF_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit, directed scenarios plus
//               randomized traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int MC_LAT  = 4;
    localparam int PERF_W  = 4;
    localparam int CNT_MAX = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rt;
    logic              id_jump;
    logic              ex_mem_read;
    logic [4:0]        ex_rt;
    logic              ex_branch_taken;
    logic              ex_mc_start;
    logic              perf_clr;
    logic              pc_lock;
    logic              ifid_lock;
    logic              ifid_flush;
    logic              idex_lock;
    logic              idex_flush;
    logic              exmem_flush;
    logic              mc_busy;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    logic [6:0]        dut_outs;

    int errors = 0;
    int checks = 0;

    // Reference state: cycles elapsed since the multi-cycle op entered EX (0 = none).
    int m_age   = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_unit #(
        .MC_LAT          (MC_LAT),
        .PERF_W          (PERF_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_start     (ex_mc_start),
        .perf_clr        (perf_clr),
        .pc_lock         (pc_lock),
        .ifid_lock       (ifid_lock),
        .ifid_flush      (ifid_flush),
        .idex_lock       (idex_lock),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .mc_busy         (mc_busy),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    assign dut_outs = {pc_lock, ifid_lock, ifid_flush, idex_lock, idex_flush, exmem_flush, mc_busy};

    // {pc_lock, ifid_lock, ifid_flush, idex_lock, idex_flush, exmem_flush, mc_busy}
    function automatic logic [6:0] model_outs();
        logic [6:0] o;
        bit         busy;
        bit         load_use;
        busy     = (m_age != 0);
        load_use = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        o        = '0;
        o[0]     = busy;
        if (rst) begin
            if (busy) begin
                if (m_age < MC_LAT - 1) o[6:1] = 6'b110101;
            end else if (ex_branch_taken) o[6:1] = 6'b001010;
            else if (ex_mc_start)         o[6:1] = 6'b110101;
            else if (load_use)            o[6:1] = 6'b110010;
            else if (id_jump)             o[6:1] = 6'b001000;
        end
        return o;
    endfunction

    task automatic model_update();
        logic [6:0] o;
        o = model_outs();
        if (!rst) begin
            m_age   = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (perf_clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (o[6] && m_stall < CNT_MAX) m_stall++;
                if (o[4] && m_flush < CNT_MAX) m_flush++;
            end
            if (m_age != 0)                            m_age = (m_age == MC_LAT - 1) ? 0 : m_age + 1;
            else if (!ex_branch_taken && ex_mc_start)  m_age = 1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rt      = 1'b0;
        id_jump         = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rt           = 5'd0;
        ex_branch_taken = 1'b0;
        ex_mc_start     = 1'b0;
        perf_clr        = 1'b0;
    endtask

    task automatic clear_perf();
        idle_inputs();
        perf_clr = 1'b1;
        advance();
        perf_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst             = 1'b0;
        ex_branch_taken = 1'b1;
        ex_mc_start     = 1'b1;
        ex_mem_read     = 1'b1;
        ex_rt           = 5'd5;
        id_rs           = 5'd5;
        id_jump         = 1'b1;
        advance();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (dut_outs[6:1] !== 6'b0) begin
                errors++;
                $display("FAIL reset_outs[%0d]: got %b want 000000", i, dut_outs[6:1]);
            end
            checks++;
            if ({mc_busy, stall_cnt, flush_cnt} !== '0) begin
                errors++;
                $display("FAIL reset_state[%0d]: busy=%b stall=%0d flush=%0d want 0/0/0",
                         i, mc_busy, stall_cnt, flush_cnt);
            end
            advance();
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    task automatic test_load_use();
        clear_perf();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_jump = 1'b1;
        @(negedge clk);
        checks++;
        if ({pc_lock, ifid_lock, idex_flush, ifid_flush, idex_lock} !== 5'b11100) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 11100", {pc_lock, ifid_lock, idex_flush, ifid_flush, idex_lock});
        end
        advance();
        ex_mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if ({pc_lock, idex_flush, ifid_flush, stall_cnt} !== {3'b001, 4'd1}) begin
            errors++;
            $display("FAIL load_use_one_cycle: got lock=%b bub=%b jflush=%b stall=%0d want 0 0 1 1",
                     pc_lock, idex_flush, ifid_flush, stall_cnt);
        end
        advance();
        id_jump = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        @(negedge clk);
        checks++;
        if ({pc_lock, idex_flush} !== 2'b00) begin
            errors++;
            $display("FAIL load_use_r0: got %b want 00", {pc_lock, idex_flush});
        end
        advance();
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        @(negedge clk);
        checks++;
        if ({pc_lock, idex_flush} !== 2'b00) begin
            errors++;
            $display("FAIL load_use_rt_unused: got %b want 00", {pc_lock, idex_flush});
        end
        advance();
        id_uses_rt = 1'b1;
        @(negedge clk);
        checks++;
        if ({pc_lock, ifid_lock, idex_flush} !== 3'b111) begin
            errors++;
            $display("FAIL load_use_rt: got %b want 111", {pc_lock, ifid_lock, idex_flush});
        end
        advance();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({stall_cnt, flush_cnt} !== {4'd2, 4'd1}) begin
            errors++;
            $display("FAIL load_use_counts: got stall=%0d flush=%0d want 2 1", stall_cnt, flush_cnt);
        end
        advance();
    endtask

    task automatic test_branch_priority();
        clear_perf();
        ex_branch_taken = 1'b1; ex_mc_start = 1'b1; id_jump = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        @(negedge clk);
        checks++;
        if (dut_outs[6:1] !== 6'b001010) begin
            errors++;
            $display("FAIL branch_priority: got %b want 001010", dut_outs[6:1]);
        end
        advance();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({mc_busy, flush_cnt, stall_cnt} !== {1'b0, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL branch_after: got busy=%b flush=%0d stall=%0d want 0 1 0",
                     mc_busy, flush_cnt, stall_cnt);
        end
        advance();
    endtask

    task automatic test_multicycle(input int nops, input string tag);
        bit exp_lock;
        bit exp_busy;
        clear_perf();
        ex_mc_start = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2; id_jump = 1'b1;
        for (int i = 0; i < MC_LAT * nops; i++) begin
            exp_lock = (i % MC_LAT) < MC_LAT - 1;
            exp_busy = (i % MC_LAT) != 0;
            @(negedge clk);
            checks++;
            if ({pc_lock, ifid_lock, idex_lock, exmem_flush, ifid_flush, idex_flush, mc_busy}
                !== {{4{exp_lock}}, 2'b00, exp_busy}) begin
                errors++;
                $display("FAIL %s[%0d]: got locks=%b flushes=%b busy=%b want %b 00 %b", tag, i,
                         {pc_lock, ifid_lock, idex_lock, exmem_flush}, {ifid_flush, idex_flush},
                         mc_busy, {4{exp_lock}}, exp_busy);
            end
            advance();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({mc_busy, stall_cnt} !== {1'b0, 4'((MC_LAT - 1) * nops)}) begin
            errors++;
            $display("FAIL %s_stall_cnt: got busy=%b stall=%0d want 0 %0d", tag, mc_busy,
                     stall_cnt, (MC_LAT - 1) * nops);
        end
        advance();
    endtask

    task automatic test_reset_mid_busy();
        idle_inputs();
        ex_mc_start = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_outs[6:1] !== 6'b0) begin
            errors++;
            $display("FAIL mid_busy_reset: got %b want 000000", dut_outs[6:1]);
        end
        advance();
        rst = 1'b1;
        ex_mc_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({dut_outs, stall_cnt} !== '0) begin
                errors++;
                $display("FAIL mid_busy_after[%0d]: got outs=%b stall=%0d want 0 0", i, dut_outs, stall_cnt);
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        clear_perf();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        repeat (20) advance();
        idle_inputs();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL stall_saturate: got %0d want 15", stall_cnt);
        end
        repeat (20) advance();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({flush_cnt, stall_cnt} !== {4'd15, 4'd15}) begin
            errors++;
            $display("FAIL flush_saturate: got flush=%0d stall=%0d want 15 15", flush_cnt, stall_cnt);
        end
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; perf_clr = 1'b1;
        advance();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({stall_cnt, flush_cnt} !== 8'd0) begin
            errors++;
            $display("FAIL perf_clr_priority: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
        end
        advance();
    endtask

    task automatic test_random(input int ncycles);
        logic [6:0] exp;
        for (int i = 0; i < ncycles; i++) begin
            rst             = ($urandom_range(0, 39) != 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_mc_start     = ($urandom_range(0, 5) == 0);
            ex_mem_read     = $urandom_range(0, 1) == 1;
            ex_rt           = 5'($urandom_range(0, 3));
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rt      = $urandom_range(0, 1) == 1;
            id_jump         = ($urandom_range(0, 3) == 0);
            perf_clr        = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            exp = model_outs();
            checks++;
            if (dut_outs !== exp) begin
                errors++;
                $display("FAIL random_outs[%0d]: got %b want %b", i, dut_outs, exp);
            end
            checks++;
            if ({stall_cnt, flush_cnt} !== {4'(m_stall), 4'(m_flush)}) begin
                errors++;
                $display("FAIL random_cnts[%0d]: got stall=%0d flush=%0d want %0d %0d",
                         i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
            advance();
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_multicycle(1, "multicycle");
        test_multicycle(2, "back_to_back");
        test_reset_mid_busy();
        test_saturation();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
